// File: rtl/br_resolve_unit_pkg.sv
// Shared types and sizing for the branch resolve unit.
//   ROB_DEPTH / ROB_IDX_W : ROB size and id width
//   br_resolve_entry_t    : one resolved-branch record
//   br_recover_state_t    : commit-time recovery FSM states
package br_resolve_unit_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic        valid;
        logic        mispred;
        logic [31:0] target;
    } br_resolve_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WAIT_REDIR
    } br_recover_state_t;

endpackage

// File: rtl/br_resolve_unit_if.sv
// Bundle of the branch CDB, ROB head, fetch redirect and statistics signals.
//   master : environment side (CDB producer, ROB, fetch)
//   slave  : br_resolve_unit
interface br_resolve_unit_if;
    import br_resolve_unit_pkg::*;

    logic                 br_cdb_valid;
    logic [ROB_IDX_W-1:0] br_cdb_rob_id;
    logic                 br_cdb_miss_predict;
    logic [31:0]          br_cdb_target_address;
    logic [ROB_IDX_W-1:0] rob_head_id;
    logic                 rob_head_is_br;
    logic                 rob_commit;
    logic                 head_br_resolved;
    logic                 commit_stall;
    logic                 flush;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 redirect_ready;
    logic [31:0]          br_commit_cnt;
    logic [31:0]          br_mispred_cnt;

    modport master (
        output br_cdb_valid, br_cdb_rob_id, br_cdb_miss_predict, br_cdb_target_address,
        output rob_head_id, rob_head_is_br, rob_commit, redirect_ready,
        input  head_br_resolved, commit_stall, flush, redirect_valid, redirect_pc,
        input  br_commit_cnt, br_mispred_cnt
    );

    modport slave (
        input  br_cdb_valid, br_cdb_rob_id, br_cdb_miss_predict, br_cdb_target_address,
        input  rob_head_id, rob_head_is_br, rob_commit, redirect_ready,
        output head_br_resolved, commit_stall, flush, redirect_valid, redirect_pc,
        output br_commit_cnt, br_mispred_cnt
    );

endinterface

// File: rtl/br_resolve_unit_table.sv
// Per-ROB-entry resolved-branch table.
//   wr_*      : CDB capture
//   clr_*     : clear of the committing entry (wins over a same-entry write)
//   flush_all : clear every valid bit
//   rd_id     : lookup index; rd_entry includes a same-cycle CDB bypass
module br_resolve_unit_table
    import br_resolve_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ROB_IDX_W-1:0] wr_id,
    input  logic                 wr_mispred,
    input  logic [31:0]          wr_target,
    input  logic                 clr_en,
    input  logic [ROB_IDX_W-1:0] clr_id,
    input  logic                 flush_all,
    input  logic [ROB_IDX_W-1:0] rd_id,
    output br_resolve_entry_t    rd_entry
);

    br_resolve_entry_t entries [ROB_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (flush_all) begin
                    entries[i].valid <= 1'b0;
                end else if (clr_en && clr_id == ROB_IDX_W'(i)) begin
                    entries[i].valid <= 1'b0;
                end else if (wr_en && wr_id == ROB_IDX_W'(i)) begin
                    entries[i] <= '{valid: 1'b1, mispred: wr_mispred, target: wr_target};
                end
            end
        end
    end

    always_comb begin
        rd_entry = entries[rd_id];
        if (wr_en && wr_id == rd_id) begin
            rd_entry = '{valid: 1'b1, mispred: wr_mispred, target: wr_target};
        end
    end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: captures branch CDB results, gates ROB commit of
// unresolved branches and runs commit-time mispredict recovery.
//   clk, rst_n : clock, async active-low reset
//   bus        : CDB / ROB head / fetch redirect / counters (slave side)
//
// state      | meaning
// IDLE       | normal operation, CDB captured, commits accepted
// FLUSH      | cycle after a mispredicted commit; flush pulse, redirect offered
// WAIT_REDIR | redirect held until fetch accepts it
module br_resolve_unit
    import br_resolve_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    br_resolve_unit_if.slave  bus
);

    br_recover_state_t state, state_nxt;
    br_resolve_entry_t head_entry;
    logic              idle;
    logic              cdb_wr;
    logic              commit_fire;
    logic              mispred_commit;
    logic              flush_int;
    logic              redirect_valid_int;
    logic              commit_stall_int;
    logic [31:0]       redirect_pc_q;
    logic [31:0]       commit_cnt_q;
    logic [31:0]       mispred_cnt_q;

    assign idle           = (state == IDLE);
    assign cdb_wr         = bus.br_cdb_valid && idle;
    assign commit_fire    = bus.rob_commit && bus.rob_head_is_br && idle;
    assign mispred_commit = commit_fire && head_entry.valid && head_entry.mispred;

    br_resolve_unit_table u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cdb_wr),
        .wr_id      (bus.br_cdb_rob_id),
        .wr_mispred (bus.br_cdb_miss_predict),
        .wr_target  (bus.br_cdb_target_address),
        .clr_en     (commit_fire),
        .clr_id     (bus.rob_head_id),
        .flush_all  (state == FLUSH),
        .rd_id      (bus.rob_head_id),
        .rd_entry   (head_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        flush_int          = 1'b0;
        redirect_valid_int = 1'b0;
        commit_stall_int   = 1'b0;
        case (state)
            IDLE: begin
                if (mispred_commit) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush_int          = 1'b1;
                redirect_valid_int = 1'b1;
                commit_stall_int   = 1'b1;
                state_nxt          = bus.redirect_ready ? IDLE : WAIT_REDIR;
            end
            WAIT_REDIR: begin
                redirect_valid_int = 1'b1;
                commit_stall_int   = 1'b1;
                if (bus.redirect_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_q <= '0;
            commit_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (commit_fire) begin
            commit_cnt_q <= commit_cnt_q + 32'd1;
            if (mispred_commit) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
                redirect_pc_q <= head_entry.target;
            end
        end
    end

    // rst_n gates the bypass path so the output is low throughout reset
    assign bus.head_br_resolved = rst_n && bus.rob_head_is_br && head_entry.valid;
    assign bus.commit_stall     = commit_stall_int;
    assign bus.flush            = flush_int;
    assign bus.redirect_valid   = redirect_valid_int;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.br_commit_cnt    = commit_cnt_q;
    assign bus.br_mispred_cnt   = mispred_cnt_q;

    a_commit_resolved: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.rob_commit && bus.rob_head_is_br && idle) |-> bus.head_br_resolved
    );

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Consumer end of the branch CDB. Captures each resolved-branch broadcast (rob_id, miss_predict, target_address) into a per-ROB-entry table.
- Gates ROB commit of branches until they have resolved.
- When a mispredicted branch commits, it runs commit-time recovery: a one-cycle pipeline flush plus a fetch redirect held under a valid/ready handshake.
- Sits between the branch CDB, the ROB head and the fetch PC logic.

Parameters:
ROB_DEPTH, 32, number of ROB entries; power of two.
ROB_IDX_W, $clog2(ROB_DEPTH), ROB id width.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
br_cdb_valid  in  1  branch CDB broadcast valid.
br_cdb_rob_id  in  ROB_IDX_W  ROB id of the resolved branch.
br_cdb_miss_predict  in  1  resolved outcome differs from the prediction.
br_cdb_target_address  in  32  correct next PC.
rob_head_id  in  ROB_IDX_W  ROB head index.
rob_head_is_br  in  1  head entry is a branch/jump.
rob_commit  in  1  head commits this cycle.
head_br_resolved  out  1  head branch has a resolution (with bypass).
commit_stall  out  1  ROB must not commit.
flush  out  1  one-cycle pulse that kills all in-flight state.
redirect_valid  out  1  fetch redirect request.
redirect_pc  out  32  redirect target.
redirect_ready  in  1  fetch accepts the redirect.
br_commit_cnt  out  32  committed branches (wraps).
br_mispred_cnt  out  32  committed mispredicts (wraps).

Behaviour:
- Reset (async, rst_n=0): all table valid bits 0, FSM=IDLE, counters 0, redirect_pc 0. All outputs 0 during reset.
- Table: per entry valid, mispred, target[31:0].
  - Write on br_cdb_valid while FSM=IDLE: valid=1, mispred and target from the CDB.
  - br_cdb_valid in FLUSH/WAIT_REDIR is dropped; those results are wrong-path.
- Head lookup:
  - head_br_resolved = table[rob_head_id].valid, OR (br_cdb_valid && FSM==IDLE && br_cdb_rob_id==rob_head_id).
  - On a same-id match the bypass also supplies mispred and target from the CDB.
  - head_br_resolved is 0 when rob_head_is_br=0.
  - The ROB must not raise rob_commit on a branch head unless head_br_resolved=1. A violation is an assertion failure.
- Commit:
  - rob_commit && rob_head_is_br in IDLE clears table[rob_head_id].valid at the next edge and increments br_commit_cnt.
  - If the looked-up mispred=1, it also increments br_mispred_cnt, registers redirect_pc<=target, and sets FSM<=FLUSH.
- FSM states and transitions:
  - IDLE: commit_stall=0, flush=0, redirect_valid=0. Moves to FLUSH on a mispredicted branch commit.
  - FLUSH: exactly one cycle, the cycle after the commit. flush=1, redirect_valid=1, commit_stall=1. All table valid bits cleared at the end of this cycle. Next state IDLE if redirect_ready, else WAIT_REDIR.
  - WAIT_REDIR: flush=0, redirect_valid=1, commit_stall=1. redirect_pc stays stable. Moves to IDLE when redirect_ready=1.
- Latency: mispredicted commit at cycle N gives flush and redirect_valid at N+1. Minimum recovery window is 1 cycle.
- rob_commit asserted while commit_stall=1 is ignored: no table change, no counter change.
- Boundary cases:
  - A CDB write to the entry being committed in the same cycle: the commit clear wins; the entry ends invalid.
  - A CDB write to a different entry in the commit cycle that enters FLUSH is still written, then cleared by the flush.
  - rob_id wrap-around needs no special handling; the table is indexed directly.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Reset asserted mid-FLUSH/WAIT_REDIR returns to IDLE immediately (asynchronously). redirect_valid drops without a handshake.

Decomposition:
- Shared package (cpu_params / a br types package): ROB_DEPTH, ROB_IDX_W, br_resolve_entry_t {valid, mispred, target}, br_recover_state_t enum {IDLE, FLUSH, WAIT_REDIR}.
- Optional sub-module br_resolve_table: storage, write/clear/flush-clear and read with bypass.
- The FSM and counters stay in the top module.

Test Plan:
1. Correct branch: CDB rob_id=3, miss_predict=0. Next cycle head=3, is_br=1 -> head_br_resolved=1. Commit -> br_commit_cnt=1, br_mispred_cnt=0, flush never asserts.
2. Mispredict with immediate ready: CDB rob_id=5, mp=1, target=0x1000_0040. Commit head=5 at N with redirect_ready=1 -> at N+1 flush=1, redirect_valid=1, redirect_pc=0x1000_0040. N+2 in IDLE with all table valids 0.
3. Redirect backpressure: repeat scenario 2 with redirect_ready=0 for 4 cycles -> flush high only at N+1; redirect_valid and commit_stall held for 5 cycles with pc stable; rob_commit during this window is ignored.
4. Bypass: CDB rob_id=7, mp=1, target=0x80 in the same cycle as head=7 -> head_br_resolved=1; commit that cycle -> flush at N+1, redirect_pc=0x80, entry 7 invalid afterwards.
5. Wrong-path drop: during WAIT_REDIR send CDB rob_id=9 -> after return to IDLE, head=9 shows head_br_resolved=0.
6. Async reset: assert rst_n=0 mid-cycle in WAIT_REDIR -> redirect_valid, commit_stall and counters go to 0 without a clock edge; FSM is IDLE after release.
